// File: rtl/ram_bist_ctrl.sv
// Single-pass RAM self-test: writes an address-derived pattern to every word,
// then reads each word back and counts mismatches against the same pattern.
module ram_bist_ctrl #(
  parameter int ADDR_SIZE   = 10,
  parameter int WORD_SIZE   = 8,
  parameter int MEMORY_SIZE = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pattern_sel,
  input  logic [WORD_SIZE-1:0] ram_rdata,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  output logic                 ram_wr,
  output logic                 ram_cs,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_SIZE:0]   err_count,
  output logic [ADDR_SIZE-1:0] first_err_addr,
  output logic [1:0]           state_dbg
);

  // Handshake: start is sampled only in IDLE; busy rises the cycle after
  // acceptance and stays high through DONE; done pulses for exactly one cycle.
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [ADDR_SIZE-1:0] K_LAST  = ADDR_SIZE'(MEMORY_SIZE - 1);
  localparam logic [ADDR_SIZE:0]   ERR_MAX = (ADDR_SIZE + 1)'(MEMORY_SIZE);

  state_t               state;
  logic [ADDR_SIZE-1:0] k;
  logic                 sel_q;
  logic                 mismatch;

  // Word for address a is (2*a) mod 256, optionally inverted.
  function automatic logic [WORD_SIZE-1:0] pattern(input logic [ADDR_SIZE-1:0] a,
                                                   input logic inv);
    logic [7:0] v;
    v = 8'({a, 1'b0});
    pattern = WORD_SIZE'(v);
    if (inv) pattern = ~pattern;
  endfunction

  assign mismatch  = (ram_rdata != pattern(k, sel_q));
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      k              <= '0;
      sel_q          <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_wr         <= 1'b0;
      ram_cs         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state          <= WRITE;
            k              <= '0;
            sel_q          <= pattern_sel;
            ram_addr       <= '0;
            ram_wdata      <= pattern('0, pattern_sel);
            ram_wr         <= 1'b1;
            ram_cs         <= 1'b1;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
          end
        end
        WRITE: begin
          if (k == K_LAST) begin
            state    <= READ;
            k        <= '0;
            ram_addr <= '0;
            ram_wr   <= 1'b0;
          end else begin
            k         <= k + 1'b1;
            ram_addr  <= k + 1'b1;
            ram_wdata <= pattern(k + 1'b1, sel_q);
          end
        end
        READ: begin
          if (mismatch && err_count != ERR_MAX) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) first_err_addr <= k;
          end
          if (k == K_LAST) begin
            // Final compare folds into pass on the same edge.
            state  <= DONE;
            done   <= 1'b1;
            ram_cs <= 1'b0;
            pass   <= (err_count == '0) && !mismatch;
          end else begin
            k        <= k + 1'b1;
            ram_addr <= k + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural 1024x8 RAM with injectable stuck-at
// faults, directed table rows, random fault runs and multi-cycle corner cases.
module tb_ram_bist_ctrl;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int N  = 1024;
  localparam int W  = (AW + 1) + AW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pattern_sel = 1'b0;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wr, ram_cs, busy, done, pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [1:0]    state_dbg;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_cnt = 0;

  logic [DW-1:0] mem   [N];
  logic [DW-1:0] or_m  [N];
  logic [DW-1:0] and_m [N];
  logic [W-1:0]  exp_q [$];

  ram_bist_ctrl #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .MEMORY_SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern_sel(pattern_sel),
    .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wr(ram_wr), .ram_cs(ram_cs), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM model: stuck-at faults applied on the read path
  always @(posedge clk) begin
    if (ram_cs && ram_wr) begin
      mem[ram_addr] <= ram_wdata;
      wr_cnt++;
    end
  end
  assign ram_rdata = (mem[ram_addr] & and_m[ram_addr]) | or_m[ram_addr];

  always @(negedge clk) begin
    if (rst_n) begin
      n_chk++;
      if (ram_wr && !ram_cs) begin
        n_fail++;
        $display("FAIL wr_without_cs: ram_wr=%0d ram_cs=%0d", ram_wr, ram_cs);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_pat(input int a, input logic inv);
    int v;
    v = (2 * a) % 256;
    if (inv) v = 255 - v;
    return 8'(v);
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      or_m[i]  = 8'h00;
      and_m[i] = 8'hFF;
    end
  endtask

  // Reference: walk every address, apply the fault masks to the written word.
  function automatic logic [W-1:0] ref_result(input logic sel);
    int errs;
    int first;
    logic [7:0] e, g;
    errs = 0;
    first = 0;
    for (int a = 0; a < N; a++) begin
      e = ref_pat(a, sel);
      g = (e & and_m[a]) | or_m[a];
      if (g != e) begin
        if (errs == 0) first = a;
        errs++;
      end
    end
    return {(AW + 1)'(errs), AW'(first), (errs == 0)};
  endfunction

  // driver: one start pulse, returns cycles from acceptance to done
  task automatic run_pass(input logic sel, output int cyc);
    @(negedge clk);
    start = 1'b1;
    pattern_sel = sel;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    chk("c1_busy", busy, 1);
    chk("c1_wr", ram_wr, 1);
    chk("c1_addr", ram_addr, 0);
    chk("c1_wdata", ram_wdata, ref_pat(0, sel));
    chk("c1_err_clear", err_count, 0);
    chk("c1_pass_clear", pass, 0);
    while (!done && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("done_cycle", cyc, 2049);
  endtask

  task automatic post_done(input logic exp_pass);
    @(posedge clk);
    #1;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("post_pass_hold", pass, exp_pass);
  endtask

  typedef struct {
    logic       sel;
    int         fa0;
    int         fa1;
    int         exp_err;
    int         exp_first;
    logic       exp_pass;
    int         mem_addr;
    logic [7:0] mem_val;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cyc;
    int nf, a, b;
    int nd, d0, d1;
    logic sel;
    logic [W-1:0] exp_v;

    vecs[0] = '{1'b0,  -1,  -1, 0,  0, 1'b1,   5, 8'd10};
    vecs[1] = '{1'b0,   5,  -1, 1,  5, 1'b0, 200, 8'd144};
    vecs[2] = '{1'b0, 300,  17, 2, 17, 1'b0,   5, 8'd10};
    vecs[3] = '{1'b1,  -1,  -1, 0,  0, 1'b1,   5, 8'd245};
    vecs[4] = '{1'b0,  -1,  -1, 0,  0, 1'b1, 200, 8'd144};

    for (int i = 0; i < N; i++) mem[i] = 8'h00;
    clear_faults();

    #3;
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_wr", ram_wr, 0);
    chk("rst_cs", ram_cs, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_err_addr, 0);
    chk("rst_state", state_dbg, 0);
    #20;
    rst_n = 1'b1;

    // directed table: bit0 stuck-at-1 faults
    for (int v = 0; v < 5; v++) begin
      clear_faults();
      if (vecs[v].fa0 >= 0) or_m[vecs[v].fa0] = 8'h01;
      if (vecs[v].fa1 >= 0) or_m[vecs[v].fa1] = 8'h01;
      run_pass(vecs[v].sel, cyc);
      chk("tbl_err", err_count, vecs[v].exp_err);
      chk("tbl_first", first_err_addr, vecs[v].exp_first);
      chk("tbl_pass", pass, vecs[v].exp_pass);
      chk("tbl_mem", mem[vecs[v].mem_addr], vecs[v].mem_val);
      post_done(vecs[v].exp_pass);
    end

    // random fault runs against the reference model
    for (int r = 0; r < 4; r++) begin
      clear_faults();
      sel = 1'($urandom_range(0, 1));
      nf = $urandom_range(0, 3);
      for (int f = 0; f < nf; f++) begin
        a = $urandom_range(0, N - 1);
        b = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) or_m[a][b] = 1'b1;
        else and_m[a][b] = 1'b0;
      end
      exp_q.push_back(ref_result(sel));
      run_pass(sel, cyc);
      exp_v = exp_q.pop_front();
      chk("rnd_err", err_count, exp_v[W-1 -: AW+1]);
      chk("rnd_first", first_err_addr, exp_v[AW:1]);
      chk("rnd_pass", pass, exp_v[0]);
      post_done(exp_v[0]);
    end
    clear_faults();

    // start held high: back-to-back runs
    @(negedge clk);
    start = 1'b1;
    pattern_sel = 1'b0;
    nd = 0;
    d0 = 0;
    d1 = 0;
    for (int i = 1; i <= 5000; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (nd == 0) d0 = i;
        if (nd == 1) d1 = i;
        nd++;
      end
    end
    start = 1'b0;
    chk("held_done_count", nd, 2);
    chk("held_first_done", d0, 2049);
    chk("held_gap", d1 - d0, 2050);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // reset in the middle of WRITE
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i < 500; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_write_wr", ram_wr, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_wr", ram_wr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cs", ram_cs, 0);
    chk("abort_addr", ram_addr, 0);
    chk("abort_state", state_dbg, 0);
    a = wr_cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_writes", wr_cnt, a);
    @(negedge clk);
    rst_n = 1'b1;
    run_pass(1'b0, cyc);
    chk("restart_pass", pass, 1);
    chk("restart_err", err_count, 0);
    post_done(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 10, RAM address width.
REQ-002 Parameter WORD_SIZE, default 8, RAM data width.
REQ-003 Parameter MEMORY_SIZE, default 1024, number of words tested (2**ADDR_SIZE).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; all other behaviour is synchronous to the clock's rising edge.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request to run one test pass; sampled only in IDLE.
REQ-008 pattern_sel  input  1  0: expected word = (2*k) mod 256; 1: bitwise inverse of that; sampled with start.
REQ-009 ram_rdata  input  WORD_SIZE  RAM data_out, combinational function of ram_addr.
REQ-010 ram_addr  output  ADDR_SIZE  registered RAM address.
REQ-011 ram_wdata  output  WORD_SIZE  registered RAM data_in.
REQ-012 ram_wr  output  1  registered RAM write enable, active high.
REQ-013 ram_cs  output  1  registered RAM chip select, active high.
REQ-014 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 pass  output  1  1 when the last completed run had zero mismatches; held until the next accepted start.
REQ-017 err_count  output  ADDR_SIZE+1  mismatch count of the current or last run.
REQ-018 first_err_addr  output  ADDR_SIZE  address of the first mismatch in the current or last run.

Function
REQ-019 FSM states SHALL be IDLE, WRITE, READ, DONE; the address counter k SHALL be ADDR_SIZE bits.
REQ-020 IDLE: ram_wr=0, ram_cs=0, busy=0; start=1 at an edge -> WRITE, k=0, latch pattern_sel, clear err_count, first_err_addr and pass.
REQ-021 WRITE: each cycle drive ram_addr=k, ram_wdata=pattern(k), ram_wr=1, ram_cs=1; k increments; after k=MEMORY_SIZE-1 -> READ with k wrapping to 0.
REQ-022 READ: each cycle drive ram_addr=k, ram_wr=0, ram_cs=1; at the closing edge compare ram_rdata with pattern(k).
REQ-023 On a mismatch, err_count SHALL increment; first_err_addr SHALL be loaded only when err_count was 0.
REQ-024 err_count SHALL NOT wrap; its maximum value is MEMORY_SIZE.
REQ-025 After the READ compare at k=MEMORY_SIZE-1 -> DONE, where done=1, ram_cs=0, ram_wr=0 and pass=(err_count==0); the next state is IDLE.
REQ-026 Latency: start accepted at edge 0; WRITE occupies cycles 1..1024, READ 1025..2048, done high in cycle 2049, busy low from cycle 2050.
REQ-027 start SHALL be ignored while busy=1 or in DONE; start held high continuously SHALL launch a new run from IDLE, one cycle after done.
REQ-028 pattern(k) SHALL be truncated to WORD_SIZE bits; addresses k and k+128 SHALL carry identical patterns.
REQ-029 ram_wr SHALL never be 1 while ram_cs=0.

Reset
REQ-030 With rst_n=0, all outputs SHALL immediately take these values: ram_addr=0, ram_wdata=0, ram_wr=0, ram_cs=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0; the FSM SHALL go to IDLE and k to 0.
REQ-031 Reset during WRITE or READ SHALL abort the run with no further RAM writes; a run after reset release SHALL start from k=0.

Verification
REQ-032 Fault-free 1024x8 RAM model, pattern_sel=0, start pulse -> done in cycle 2049, pass=1, err_count=0, RAM word 5 = 10, word 200 = 144.
REQ-033 RAM model with bit0 stuck-at-1 at address 5 -> err_count=1, first_err_addr=5, pass=0.
REQ-034 Faults at addresses 300 and 17 -> err_count=2, first_err_addr=17.
REQ-035 pattern_sel=1 on a fault-free RAM -> word 5 written as 245, pass=1; a following run with pattern_sel=0 clears err_count to 0 at acceptance.
REQ-036 rst_n asserted at cycle 500 of WRITE -> ram_wr=0 and busy=0 with no clock edge; a restart completes with pass=1.
REQ-037 start held high for 5000 cycles -> exactly two done pulses, 2050 cycles apart; no start is accepted while busy.
